// File: rtl/lockin_ctrl_pkg.sv
// Shared types and default sizes for the clock period meter.
package lockin_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } meter_state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 65535;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus one edge register for an asynchronous input.
// Latency: edge flags appear 2 cycles after capture; no backpressure (free running).
module edge_sync (
  input  logic clock_in,
  input  logic reset_n,
  input  logic signal_in,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

endmodule

// File: rtl/clock_period_meter.sv
// Averages the period (and, with CLOCK_PERIOD_METER_DUTY_EN, the high time) of a slow async signal.
// Latency: period_valid pulses the cycle after the edge that completes a 2^AVG_LOG2 group.
// Backpressure: none; results overwrite, timeout is a level while edges are missing.
module clock_period_meter
  import lockin_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             signal_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int NS_W  = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [NS_W-1:0]  LAST_SAMPLE = NS_W'((1 << AVG_LOG2) - 1);

  logic rise;
  logic fall;

  edge_sync u_edge_sync (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .signal_in (signal_in),
    .rise      (rise),
    .fall      (fall)
  );

  meter_state_t     state_q;
  meter_state_t     state_d;
  logic             start;
  logic             take;
  logic             expire;
  logic             group_done;
  logic [CNT_W-1:0] cnt_q;
  logic [NS_W-1:0]  nsamp_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    take    = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE, STALL: begin
        if (rise) begin
          start   = 1'b1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // An edge landing on the TIMEOUT count wins over the timeout.
        if (rise) begin
          take = 1'b1;
        end else if (cnt_q == TIMEOUT_CNT) begin
          expire  = 1'b1;
          state_d = STALL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign group_done = take && (nsamp_q == LAST_SAMPLE);
  assign acc_sum    = acc_q + ACC_W'(cnt_q);

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nsamp_q      <= '0;
      acc_q        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_valid <= group_done;
      if (start) begin
        cnt_q   <= ONE;
        nsamp_q <= '0;
        acc_q   <= '0;
        timeout <= 1'b0;
      end else if (take) begin
        cnt_q <= ONE;
        if (group_done) begin
          period  <= CNT_W'(acc_sum >> AVG_LOG2);
          acc_q   <= '0;
          nsamp_q <= '0;
        end else begin
          acc_q   <= acc_sum;
          nsamp_q <= nsamp_q + 1'b1;
        end
      end else if (expire) begin
        timeout <= 1'b1;
        acc_q   <= '0;
        nsamp_q <= '0;
      end else if (state_q == MEASURE) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q;
  logic [ACC_W-1:0] hacc_q;

  // High samples land on falling edges; a group always closes on a rising edge.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      hcnt_q    <= '0;
      hacc_q    <= '0;
      high_time <= '0;
    end else begin
      if (start || take) begin
        hcnt_q <= ONE;
      end else if (state_q == MEASURE) begin
        hcnt_q <= hcnt_q + 1'b1;
      end

      if (start || expire) begin
        hacc_q <= '0;
      end else if (group_done) begin
        high_time <= CNT_W'(hacc_q >> AVG_LOG2);
        hacc_q    <= '0;
      end else if (fall && state_q == MEASURE) begin
        hacc_q <= hacc_q + ACC_W'(hcnt_q);
      end
    end
  end
`else
  logic unused_fall;
  assign unused_fall = fall;
  assign high_time   = '0;
`endif

endmodule
